// File: rtl/mem_load_ctrl_if.sv
// rtl/mem_load_ctrl_if.sv - load word stream between the external source and mem_load_ctrl
interface mem_load_ctrl_if #(
  parameter int DATA_W = 16
) ();
  logic              ld_valid;
  logic              ld_ready;
  logic [DATA_W-1:0] ld_data;
  logic              ld_last;

  modport master (output ld_valid, ld_data, ld_last, input ld_ready);
  modport slave  (input ld_valid, ld_data, ld_last, output ld_ready);
endinterface

// File: rtl/mem_load_ctrl.sv
// rtl/mem_load_ctrl.sv - handshaked DRAM/IRAM preload, processor handoff and DRAM readback
module mem_load_ctrl #(
  parameter int ADDR_W    = 9,
  parameter int DATA_W    = 16,
  parameter int DRAM_BASE = 1,
  parameter int IRAM_BASE = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_go,
  mem_load_ctrl_if.slave    ld,
  input  logic              proc_done,
  input  logic [ADDR_W-1:0] proc_dram_addr,
  input  logic [DATA_W-1:0] proc_dram_wdata,
  input  logic              proc_dram_we,
  input  logic [ADDR_W-1:0] proc_iram_addr,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] dram_q,
  output logic [ADDR_W-1:0] dram_addr,
  output logic [DATA_W-1:0] dram_wdata,
  output logic              dram_we,
  output logic              dram_re,
  output logic [ADDR_W-1:0] iram_addr,
  output logic [DATA_W-1:0] iram_wdata,
  output logic              iram_we,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              start,
  output logic              owner,
  output logic              busy,
  output logic [ADDR_W:0]   d_count,
  output logic [ADDR_W:0]   i_count,
  output logic              ovf
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD_D, S_LOAD_I, S_RUN, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] DB      = ADDR_W'(DRAM_BASE);
  localparam logic [ADDR_W-1:0] IB      = ADDR_W'(IRAM_BASE);
  localparam logic [ADDR_W-1:0] TOP     = '1;
  localparam logic [ADDR_W:0]   CNT_ONE = 1;

  state_t            state, state_nxt;
  logic              accept, go_ok, idle_like;
  logic [ADDR_W-1:0] d_ptr, i_ptr;
  logic              d_top, i_top;
  // last IRAM word accepted; its write occupies one more LOAD_I cycle before RUN
  logic              i_flush;
  logic [ADDR_W-1:0] q_dram_addr, q_iram_addr;
  logic [DATA_W-1:0] q_dram_wdata, q_iram_wdata;
  logic              q_dram_we, q_dram_re, q_iram_we, q_rd_valid, q_start;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign go_ok     = load_go && idle_like;
  assign accept    = ld.ld_valid && ld.ld_ready;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (load_go) state_nxt = S_LOAD_D;
      S_LOAD_D:       if (accept && ld.ld_last) state_nxt = S_LOAD_I;
      S_LOAD_I:       if (i_flush) state_nxt = S_RUN;
      S_RUN:          if (proc_done) state_nxt = S_DONE;
      default:        state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    owner       = (state == S_RUN);
    busy        = (state == S_LOAD_D) || (state == S_LOAD_I) || (state == S_RUN);
    ld.ld_ready = (state == S_LOAD_D) || ((state == S_LOAD_I) && !i_flush);
    start       = q_start;
    rd_valid    = q_rd_valid;
    rd_data     = q_rd_valid ? dram_q : '0;
    if (owner) begin
      dram_addr  = proc_dram_addr;
      dram_wdata = proc_dram_wdata;
      dram_we    = proc_dram_we;
      dram_re    = 1'b0;
      iram_addr  = proc_iram_addr;
      iram_wdata = '0;
      iram_we    = 1'b0;
    end else begin
      dram_addr  = q_dram_addr;
      dram_wdata = q_dram_wdata;
      dram_we    = q_dram_we;
      dram_re    = q_dram_re;
      iram_addr  = q_iram_addr;
      iram_wdata = q_iram_wdata;
      iram_we    = q_iram_we;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_ptr        <= DB;
      i_ptr        <= IB;
      d_top        <= 1'b0;
      i_top        <= 1'b0;
      i_flush      <= 1'b0;
      d_count      <= '0;
      i_count      <= '0;
      ovf          <= 1'b0;
      q_dram_addr  <= DB;
      q_dram_wdata <= '0;
      q_dram_we    <= 1'b0;
      q_dram_re    <= 1'b0;
      q_iram_addr  <= IB;
      q_iram_wdata <= '0;
      q_iram_we    <= 1'b0;
      q_rd_valid   <= 1'b0;
      q_start      <= 1'b0;
    end else begin
      q_dram_we  <= 1'b0;
      q_iram_we  <= 1'b0;
      q_dram_re  <= 1'b0;
      q_rd_valid <= q_dram_re;
      q_start    <= (state == S_LOAD_I) && i_flush;
      if (go_ok) begin
        d_ptr   <= DB;
        i_ptr   <= IB;
        d_top   <= 1'b0;
        i_top   <= 1'b0;
        i_flush <= 1'b0;
        d_count <= '0;
        i_count <= '0;
        ovf     <= 1'b0;
      end else if (accept && (state == S_LOAD_D)) begin
        // the top address is written once; later words in the segment are dropped
        if (d_top) begin
          ovf <= 1'b1;
        end else begin
          q_dram_addr  <= d_ptr;
          q_dram_wdata <= ld.ld_data;
          q_dram_we    <= 1'b1;
          d_count      <= d_count + CNT_ONE;
          if (d_ptr == TOP) d_top <= 1'b1;
          else              d_ptr <= d_ptr + 1'b1;
        end
      end else if (accept && (state == S_LOAD_I)) begin
        if (ld.ld_last) i_flush <= 1'b1;
        if (i_top) begin
          ovf <= 1'b1;
        end else begin
          q_iram_addr  <= i_ptr;
          q_iram_wdata <= ld.ld_data;
          q_iram_we    <= 1'b1;
          i_count      <= i_count + CNT_ONE;
          if (i_ptr == TOP) i_top <= 1'b1;
          else              i_ptr <= i_ptr + 1'b1;
        end
      end else if (rd_req && idle_like) begin
        q_dram_addr <= rd_addr;
        q_dram_re   <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_mem_load_ctrl.sv
// tb/tb_mem_load_ctrl.sv - randomized self-checking bench for mem_load_ctrl
module tb_mem_load_ctrl;
  localparam int AW = 9, DW = 16, AW2 = 2;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;
  logic load_go = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, use_small = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic proc_done = 1'b0, proc_dram_we = 1'b0, rd_req = 1'b0;
  logic [AW-1:0] proc_dram_addr = '0, proc_iram_addr = '0, rd_addr = '0;
  logic [DW-1:0] proc_dram_wdata = '0;
  logic [DW-1:0] dram_q;
  logic [AW-1:0] dram_addr, iram_addr;
  logic [DW-1:0] dram_wdata, iram_wdata, rd_data;
  logic dram_we, dram_re, iram_we, rd_valid, start, owner, busy, ovf;
  logic [AW:0] d_count, i_count;

  logic [AW2-1:0] s_dram_addr, s_iram_addr;
  logic [DW-1:0] s_dram_wdata, s_iram_wdata, s_rd_data;
  logic s_dram_we, s_dram_re, s_iram_we, s_rd_valid, s_start, s_owner, s_busy, s_ovf;
  logic [AW2:0] s_d_count, s_i_count;

  mem_load_ctrl_if #(.DATA_W(DW)) lif ();
  mem_load_ctrl_if #(.DATA_W(DW)) sif ();
  assign lif.ld_valid = ld_valid & ~use_small;
  assign lif.ld_data  = ld_data;
  assign lif.ld_last  = ld_last;
  assign sif.ld_valid = ld_valid & use_small;
  assign sif.ld_data  = ld_data;
  assign sif.ld_last  = ld_last;
  wire rdy = use_small ? sif.ld_ready : lif.ld_ready;

  mem_load_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DRAM_BASE(1), .IRAM_BASE(1)) dut (
    .clk(clk), .rst(rst), .load_go(load_go & ~use_small), .ld(lif),
    .proc_done(proc_done), .proc_dram_addr(proc_dram_addr), .proc_dram_wdata(proc_dram_wdata),
    .proc_dram_we(proc_dram_we), .proc_iram_addr(proc_iram_addr), .rd_req(rd_req), .rd_addr(rd_addr),
    .dram_q(dram_q), .dram_addr(dram_addr), .dram_wdata(dram_wdata), .dram_we(dram_we), .dram_re(dram_re),
    .iram_addr(iram_addr), .iram_wdata(iram_wdata), .iram_we(iram_we), .rd_valid(rd_valid), .rd_data(rd_data),
    .start(start), .owner(owner), .busy(busy), .d_count(d_count), .i_count(i_count), .ovf(ovf));

  mem_load_ctrl #(.ADDR_W(AW2), .DATA_W(DW), .DRAM_BASE(1), .IRAM_BASE(1)) dut_small (
    .clk(clk), .rst(rst), .load_go(load_go & use_small), .ld(sif),
    .proc_done(1'b0), .proc_dram_addr('0), .proc_dram_wdata('0), .proc_dram_we(1'b0),
    .proc_iram_addr('0), .rd_req(1'b0), .rd_addr('0), .dram_q('0),
    .dram_addr(s_dram_addr), .dram_wdata(s_dram_wdata), .dram_we(s_dram_we), .dram_re(s_dram_re),
    .iram_addr(s_iram_addr), .iram_wdata(s_iram_wdata), .iram_we(s_iram_we), .rd_valid(s_rd_valid),
    .rd_data(s_rd_data), .start(s_start), .owner(s_owner), .busy(s_busy), .d_count(s_d_count),
    .i_count(s_i_count), .ovf(s_ovf));

  // DRAM behaviour: synchronous write, one-cycle registered read
  logic [DW-1:0] dmem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (dram_we) dmem[dram_addr] <= dram_wdata;
    if (dram_re) dram_q <= dmem[dram_addr];
  end

  typedef struct {int cyc; int addr; int data;} wr_t;
  wr_t dlog[$], ilog[$], slog[$];
  int n_start = 0, start_cyc = 0;
  logic start_owner = 1'b0;

  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (dram_we && !owner) dlog.push_back('{cyc, int'(dram_addr), int'(dram_wdata)});
    if (iram_we)   ilog.push_back('{cyc, int'(iram_addr), int'(iram_wdata)});
    if (s_dram_we) slog.push_back('{cyc, int'(s_dram_addr), int'(s_dram_wdata)});
    if (start) begin n_start++; start_cyc = cyc; start_owner = owner; end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Reference: segment words land at base, base+1, ... until the address space is exhausted
  task automatic check_seg(input string tag, input int sel, input int from, input int words[$],
                           input int base, input int aw);
    wr_t q[$];
    int cap, n;
    case (sel)
      0: q = dlog;
      1: q = ilog;
      default: q = slog;
    endcase
    cap = (1 << aw) - base;
    n = (words.size() < cap) ? words.size() : cap;
    check({tag, "_nwr"}, q.size() - from, n);
    for (int i = 0; i < n && from + i < q.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), q[from+i].addr, base + i);
      check($sformatf("%s_data%0d", tag, i), q[from+i].data, words[i]);
    end
  endtask

  task automatic push_word(input int d, input bit last, input int gap);
    int b = 40;
    ld_valid = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
    ld_valid = 1'b1; ld_data = DW'(d); ld_last = last;
    @(negedge clk);
    while (!rdy && b > 0) begin @(negedge clk); b--; end
    check("ld_ready", rdy, 1);
    @(posedge clk); #1;
    ld_valid = 1'b0; ld_last = 1'b0;
  endtask

  task automatic pulse_go();
    load_go = 1'b1; @(posedge clk); #1 load_go = 1'b0;
  endtask

  task automatic wait_start(input int prev, input int budget);
    int b = budget;
    while (n_start == prev && b > 0) begin @(negedge clk); b--; end
    check("start_seen", n_start - prev, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int ns, dfrom, ifrom, sfrom, nd, ni;
    int dw[$], iw[$];
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_ready", lif.ld_ready, 0);  check("rst_busy", busy, 0);
    check("rst_owner", owner, 0);         check("rst_start", start, 0);
    check("rst_dwe", dram_we, 0);         check("rst_iwe", iram_we, 0);
    check("rst_dre", dram_re, 0);         check("rst_rdv", rd_valid, 0);
    check("rst_daddr", dram_addr, 1);     check("rst_iaddr", iram_addr, 1);
    check("rst_dcnt", d_count, 0);        check("rst_ovf", ovf, 0);

    // basic load with valid held high
    dfrom = dlog.size(); ifrom = ilog.size(); ns = n_start;
    dw = '{5, 7, 9}; iw = '{100, 200};
    pulse_go();
    foreach (dw[i]) push_word(dw[i], i == 2, 0);
    foreach (iw[i]) push_word(iw[i], i == 1, 0);
    wait_start(ns, 10);
    check_seg("basic_d", 0, dfrom, dw, 1, AW);
    check_seg("basic_i", 1, ifrom, iw, 1, AW);
    if (dlog.size() >= dfrom + 3 && ilog.size() >= ifrom + 2) begin
      check("basic_dseq1", dlog[dfrom+1].cyc - dlog[dfrom].cyc, 1);
      check("basic_dseq2", dlog[dfrom+2].cyc - dlog[dfrom+1].cyc, 1);
      check("basic_i_after_d", ilog[ifrom].cyc - dlog[dfrom+2].cyc, 1);
      check("basic_iseq", ilog[ifrom+1].cyc - ilog[ifrom].cyc, 1);
      check("basic_start_lat", start_cyc - ilog[ifrom+1].cyc, 1);
    end
    check("basic_start_owner", start_owner, 1);
    check("basic_dcnt", d_count, 3);
    check("basic_icnt", i_count, 2);

    // processor pass-through; load_go and rd_req are ignored while running
    @(posedge clk); #1;
    proc_dram_we = 1'b1; proc_dram_addr = 4; proc_dram_wdata = 16'h00AA; proc_iram_addr = 7;
    load_go = 1'b1; rd_req = 1'b1; rd_addr = 4;
    @(negedge clk);
    check("run_dwe", dram_we, 1);         check("run_daddr", dram_addr, 4);
    check("run_dwdata", dram_wdata, 16'h00AA);
    check("run_iaddr", iram_addr, 7);     check("run_iwe", iram_we, 0);
    @(posedge clk); #1 proc_dram_we = 1'b0; load_go = 1'b0; rd_req = 1'b0;
    @(negedge clk);
    check("run_no_re", dram_re, 0);       check("run_busy", busy, 1);
    check("run_owner", owner, 1);         check("run_start_once", n_start - ns, 1);
    check("run_dcnt", d_count, 3);        check("run_icnt", i_count, 2);
    proc_done = 1'b1; @(posedge clk); #1 proc_done = 1'b0;
    @(negedge clk);
    check("done_owner", owner, 0);        check("done_busy", busy, 0);

    // pipelined readback
    @(posedge clk); #1 rd_req = 1'b1; rd_addr = 4;
    @(posedge clk); #1 rd_addr = 2;
    @(negedge clk);
    check("rb_re", dram_re, 1);           check("rb_addr", dram_addr, 4);
    check("rb_early_valid", rd_valid, 0);
    @(posedge clk); #1 rd_req = 1'b0;
    @(negedge clk);
    check("rb_valid0", rd_valid, 1);      check("rb_data0", rd_data, 16'h00AA);
    @(negedge clk);
    check("rb_valid1", rd_valid, 1);      check("rb_data1", rd_data, 7);

    // randomized streams, throttled or with random gaps, with ignored events injected
    for (int it = 0; it < 6; it++) begin
      dw.delete(); iw.delete();
      nd = $urandom_range(1, 8); ni = $urandom_range(1, 8);
      for (int i = 0; i < nd; i++) dw.push_back(int'($urandom_range(0, 65535)));
      for (int i = 0; i < ni; i++) iw.push_back(int'($urandom_range(0, 65535)));
      dfrom = dlog.size(); ifrom = ilog.size(); ns = n_start;
      pulse_go();
      for (int i = 0; i < nd; i++) begin
        push_word(dw[i], i == nd - 1, (it % 2 == 0) ? 1 : int'($urandom_range(0, 3)));
        if (i == 0) begin
          proc_done = 1'b1; @(posedge clk); #1 proc_done = 1'b0;
          @(negedge clk);
          check("ign_done_busy", busy, 1);
          check("ign_done_owner", owner, 0);
        end
      end
      for (int i = 0; i < ni; i++) begin
        push_word(iw[i], i == ni - 1, (it % 2 == 0) ? 1 : int'($urandom_range(0, 3)));
        if (i == 0) begin
          pulse_go();
          check("ign_go_dcnt", d_count, nd);
        end
      end
      wait_start(ns, 20);
      check_seg($sformatf("rnd%0d_d", it), 0, dfrom, dw, 1, AW);
      check_seg($sformatf("rnd%0d_i", it), 1, ifrom, iw, 1, AW);
      check("rnd_dcnt", d_count, nd);
      check("rnd_icnt", i_count, ni);
      check("rnd_ovf", ovf, 0);
      proc_done = 1'b1; @(posedge clk); #1 proc_done = 1'b0;
      @(negedge clk);
      check("rnd_done_owner", owner, 0);
      check("rnd_start_once", n_start - ns, 1);
    end

    // overflow on a 2-bit address space: only addresses 1..3 are writable
    use_small = 1'b1;
    dw.delete(); iw.delete();
    for (int i = 0; i < 5; i++) dw.push_back(int'($urandom_range(0, 65535)));
    iw.push_back(int'($urandom_range(0, 65535)));
    sfrom = slog.size();
    pulse_go();
    foreach (dw[i]) push_word(dw[i], i == 4, 0);
    push_word(iw[0], 1, 0);
    repeat (3) @(negedge clk);
    check_seg("ovf_d", 2, sfrom, dw, 1, AW2);
    check("ovf_flag", s_ovf, 1);
    check("ovf_dcnt", s_d_count, 3);
    check("ovf_icnt", s_i_count, 1);
    check("ovf_advanced", s_owner, 1);
    use_small = 1'b0;

    // reset after the second DRAM accept
    pulse_go();
    push_word(int'($urandom_range(0, 65535)), 0, 0);
    push_word(int'($urandom_range(0, 65535)), 0, 0);
    ld_valid = 1'b1; ld_data = 16'h1234; rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("mid_dwe", dram_we, 0);         check("mid_iwe", iram_we, 0);
    check("mid_ready", lif.ld_ready, 0);  check("mid_busy", busy, 0);
    check("mid_owner", owner, 0);         check("mid_dcnt", d_count, 0);
    check("mid_daddr", dram_addr, 1);     check("mid_start", start, 0);
    @(negedge clk);
    check("mid_dwe_next", dram_we, 0);
    ld_valid = 1'b0;
    dw.delete(); iw.delete();
    for (int i = 0; i < 3; i++) dw.push_back(int'($urandom_range(0, 65535)));
    iw.push_back(int'($urandom_range(0, 65535)));
    dfrom = dlog.size(); ns = n_start;
    pulse_go();
    foreach (dw[i]) push_word(dw[i], i == 2, 0);
    push_word(iw[0], 1, 0);
    wait_start(ns, 10);
    check_seg("restart_d", 0, dfrom, dw, 1, AW);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_load_ctrl.md
# mem_load_ctrl

Sequences the pre-run load of the data memory (DRAM) and instruction memory (IRAM), then hands both memories to the processor and issues `start`. It replaces the free-running, delay-based load timing with a valid/ready handshake, so no word can be overwritten or skipped. After the processor reports completion, the block returns DRAM to the external side for result readback. It sits in `top_layer` between the external load port (testbench or serial front end), the two memories and the processor core.

## Interface
- `ADDR_W`, 9, memory address width (both memories).
- `DATA_W`, 16, word width.
- `DRAM_BASE`, 1, first DRAM load address.
- `IRAM_BASE`, 1, first IRAM load address.

- `clk` in 1: single clock; all state updates on its rising edge.
- `rst` in 1: synchronous, active-high reset.
- `load_go` in 1: begin a load sequence; honoured only in IDLE or DONE.
- `ld_valid` in 1, `ld_ready` out 1: load word handshake.
- `ld_data` in DATA_W: load word.
- `ld_last` in 1: qualifies the current word as the last of the current segment.
- `proc_done` in 1: processor finished execution.
- `proc_dram_addr` in ADDR_W, `proc_dram_wdata` in DATA_W, `proc_dram_we` in 1, `proc_iram_addr` in ADDR_W: processor memory requests.
- `rd_req` in 1, `rd_addr` in ADDR_W: external DRAM readback request.
- `dram_q` in DATA_W: DRAM read data, valid one cycle after `dram_re`.
- `dram_addr` out ADDR_W, `dram_wdata` out DATA_W, `dram_we` out 1, `dram_re` out 1: DRAM port.
- `iram_addr` out ADDR_W, `iram_wdata` out DATA_W, `iram_we` out 1: IRAM port.
- `rd_valid` out 1, `rd_data` out DATA_W: readback result.
- `start` out 1: one-cycle processor start pulse.
- `owner` out 1: 0 = loader/readback owns memories, 1 = processor.
- `busy` out 1: high in LOAD_D, LOAD_I and RUN.
- `d_count` out ADDR_W+1, `i_count` out ADDR_W+1: words written per segment.
- `ovf` out 1: sticky; a segment overflowed its address space.

## Operation
- States: IDLE, LOAD_D, LOAD_I, RUN, DONE.
- Transitions:
  - IDLE/DONE + `load_go` -> LOAD_D. Pointers are set to the bases; counts and `ovf` are cleared.
  - LOAD_D + accepted word with `ld_last` -> LOAD_I.
  - LOAD_I + accepted word with `ld_last` -> RUN.
  - RUN + `proc_done` -> DONE.
- `ld_ready` = 1 only in LOAD_D/LOAD_I. `ld_valid` is ignored in every other state.
- Accept = `ld_valid & ld_ready`. An accepted word is written to the active memory at the segment pointer. The pointer and count then increment.
- Overflow: the pointer stays at all-ones. If a word is accepted while the pointer is all-ones and that address has already been written, the word is dropped and `ovf` sets. `ld_last` on a dropped word still advances the state.
- Memory port multiplexing:
  - When `owner` = 1, the DRAM/IRAM address, write data and write enable pass combinationally from the `proc_*` inputs. `iram_we` = 0 and `dram_re` = 0.
  - When `owner` = 0, the ports are driven by the block's registered outputs.
- Readback:
  - `rd_req` in IDLE or DONE registers `dram_addr` = `rd_addr` and `dram_re` = 1 for one cycle.
  - `rd_valid` = 1 with `rd_data` = `dram_q` on the following cycle.
  - `rd_req` in any other state is ignored.
- `load_go` while `busy` is ignored. `proc_done` outside RUN is ignored.

## Timing
- Reset values:
  - State IDLE; all outputs 0.
  - `dram_addr` = `DRAM_BASE`, `iram_addr` = `IRAM_BASE`; `owner` 0.
  - Reset is honoured in any state, including mid-load and mid-run. Any write in flight is abandoned; no write enable is asserted in the cycle after reset.
- Load write latency: for a word accepted at edge k, `*_we` = 1 with the address and data registered from edge k, visible during cycle k+1.
- Throughput: one word per cycle; `ld_ready` stays high through back-to-back accepts.
- The final DRAM write happens in the first LOAD_I cycle and takes no IRAM cycles.
- `start` = 1 for exactly the first cycle of RUN, which follows the final IRAM write cycle.
- `owner` rises together with `start` and falls in the first DONE cycle.
- Readback latency: `rd_req` at edge k -> `dram_re` in cycle k+1 -> `rd_valid` in cycle k+2. A new request may be issued every cycle (pipelined).

## Test plan
- Basic load: DRAM words 5, 7, 9 (last on 9), then IRAM words 100, 200 (last on 200), `ld_valid` held high.
  - Expect DRAM writes at 1, 2, 3 and IRAM writes at 1, 2 in consecutive cycles.
  - `d_count` = 3, `i_count` = 2; `start` pulses once, one cycle after the IRAM write of 200.
- Throttled source: `ld_valid` toggles every other cycle.
  - Expect no duplicate writes and no skipped addresses.
  - Memory contents equal the stream.
- Run/readback:
  - During RUN, drive `proc_dram_we` = 1, `proc_dram_addr` = 4, `proc_dram_wdata` = 0x00AA -> expect pass-through.
  - Assert `rd_req` in RUN -> expect no `dram_re`.
  - After `proc_done`, `rd_req` at address 4 -> expect `rd_valid` two cycles later with `rd_data` = 0x00AA.
- Overflow: `ADDR_W` = 2, `DRAM_BASE` = 1, send 5 DRAM words.
  - Expect writes at 1, 2, 3; words 4 and 5 dropped.
  - `ovf` = 1, `d_count` = 3; state still advances on `ld_last`.
- Reset mid-load: assert `rst` after the second DRAM accept.
  - Expect IDLE, all outputs 0, no write enable in the next cycle.
  - A new `load_go` restarts writes at address 1.
- Ignored events: `load_go` during LOAD_I or RUN, and `proc_done` during LOAD_D.
  - Expect no state change, with pointers and counts unaffected.
